muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage of the MIPS pipeline.
- Executes MULT, MULTU, DIV and DIVU over W+1 cycles and owns the architectural HI/LO registers.
- Asserts busy so the hazard logic stalls MFHI/MFLO and any new mul/div until the result is in place.
- Accepts MTHI/MTLO writes from the pipeline.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/dffre.sv | 20 ++
 rtl/muldiv_signfix.sv | 38 +++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
// The unit and its sign-fix helper import this package.
package muldiv_pkg;

  localparam int MD_W = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(MD_W);

endpackage

// File: rtl/dffre.sv
// Register with synchronous active-high reset and load enable.
module dffre #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         r,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (r) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/muldiv_signfix.sv
// Turns the raw magnitude result into architectural HI/LO values:
// sign correction for signed ops and the divide-by-zero override.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] raw,
  input  logic           is_div,
  input  logic           qsign,
  input  logic           rsign,
  input  logic           divzero,
  input  logic [W-1:0]   raw_a,
  output logic [W-1:0]   hi_nx,
  output logic [W-1:0]   lo_nx
);

  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;

  assign prod = qsign ? -raw : raw;
  assign quo  = raw[W-1:0];
  assign rem  = raw[2*W-1:W];

  always_comb begin
    hi_nx = prod[2*W-1:W];
    lo_nx = prod[W-1:0];
    if (is_div) begin
      if (divzero) begin
        hi_nx = raw_a;
        lo_nx = '1;
      end else begin
        hi_nx = rsign ? -rem : rem;
        lo_nx = qsign ? -quo : quo;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: W shift-add or
// restoring-divide steps on magnitudes, then one sign-fix cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int W = MD_W
) (
  input  logic         clk,
  input  logic         r,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = (W == MD_W) ? CNT_W : cnt_width(W);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   raw_a_q, raw_a_d;
  logic           is_div_q, is_div_d;
  logic           qsign_q, qsign_d;
  logic           rsign_q, rsign_d;
  logic           divzero_q, divzero_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           op_signed;
  logic           op_is_mul;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     add_sum;
  logic [W:0]     trial;
  logic [W:0]     diff;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign a_mag     = (op_signed && a[W-1]) ? -a : a;
  assign b_mag     = (op_signed && b[W-1]) ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign add_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opb_q : {W{1'b0}})};
  // Divide: acc = {partial remainder, unconsumed dividend / quotient bits}.
  assign trial   = acc_q[2*W-1:W-1];
  assign diff    = trial - {1'b0, opb_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    raw_a_d   = raw_a_q;
    is_div_d  = is_div_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    divzero_d = divzero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ITER;
          cnt_d     = '0;
          acc_d     = {{W{1'b0}}, a_mag};
          opb_d     = b_mag;
          raw_a_d   = a;
          is_div_d  = !op_is_mul;
          qsign_d   = op_signed && (a[W-1] ^ b[W-1]);
          rsign_d   = op_signed && a[W-1];
          divzero_d = (b == '0);
        end
      end
      S_ITER: begin
        if (is_div_q) begin
          acc_d = diff[W] ? {trial[W-1:0], acc_q[W-2:0], 1'b0}
                          : {diff[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
          acc_d = {add_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_FIX);
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      raw_a_q   <= '0;
      is_div_q  <= 1'b0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      divzero_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      raw_a_q   <= raw_a_d;
      is_div_q  <= is_div_d;
      qsign_q   <= qsign_d;
      rsign_q   <= rsign_d;
      divzero_q <= divzero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  logic [W-1:0] fix_hi;
  logic [W-1:0] fix_lo;
  logic         in_fix;
  logic         in_idle;
  logic         hi_en;
  logic         lo_en;

  muldiv_signfix #(.W(W)) u_signfix (
    .raw     (acc_q),
    .is_div  (is_div_q),
    .qsign   (qsign_q),
    .rsign   (rsign_q),
    .divzero (divzero_q),
    .raw_a   (raw_a_q),
    .hi_nx   (fix_hi),
    .lo_nx   (fix_lo)
  );

  assign in_fix  = (state_q == S_FIX);
  assign in_idle = (state_q == S_IDLE);
  assign hi_en   = in_fix || (in_idle && mthi);
  assign lo_en   = in_fix || (in_idle && mtlo);

  dffre #(.W(W)) u_hi (
    .clk (clk),
    .r   (r),
    .en  (hi_en),
    .d   (in_fix ? fix_hi : wdata),
    .q   (hi)
  );

  dffre #(.W(W)) u_lo (
    .clk (clk),
    .r   (r),
    .en  (lo_en),
    .d   (in_fix ? fix_lo : wdata),
    .q   (lo)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model checked
// every cycle, directed literal cases, then a randomized input stream.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         r = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(.W(W)) dut (
    .clk   (clk),
    .r     (r),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural result {HI,LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx;
    longint sy;
    logic [63:0] q64;
    logic [63:0] m64;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'b00: return sx * sy;
      2'b01: return {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q64 = sx / sy;
        m64 = sx % sy;
        return {m64[31:0], q64[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Reference model: W+1 busy cycles, result appears with done afterwards.
  logic [W-1:0] m_hi, m_lo;
  logic [63:0]  m_pend;
  int           m_left = 0;
  logic         m_done = 1'b0;

  always @(posedge clk) begin
    if (r) begin
      m_hi = '0;
      m_lo = '0;
      m_left = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else begin
        if (mthi) m_hi = wdata;
        if (mtlo) m_lo = wdata;
        if (start) begin
          m_pend = ref_result(op, a, b);
          m_left = W + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_left > 0);
      check("done", done, m_done);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int busy_cycles);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    check("op_timeout", done, 1'b1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc;
    int ndone;
    r = 1'b1;
    @(posedge clk);
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    r = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    do_op(2'b00, 32'd7, 32'hFFFFFFFD, bc);
    check("mult_busy_cycles", bc, 33);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);
    $display("MULT 7*-3 hi=%h lo=%h busy_cycles=%0d", hi, lo, bc);

    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, bc);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    $display("MULTU ffffffff^2 hi=%h lo=%h", hi, lo);

    do_op(2'b10, 32'hFFFFFFF9, 32'd2, bc);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_lo", lo, 32'hFFFFFFFD);
    $display("DIV -7/2 hi=%h lo=%h", hi, lo);

    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, bc);
    check("ovf_hi", hi, 32'h0);
    check("ovf_lo", lo, 32'h80000000);
    $display("DIV ovf hi=%h lo=%h", hi, lo);

    do_op(2'b11, 32'd100, 32'd0, bc);
    check("dz_hi", hi, 32'h64);
    check("dz_lo", lo, 32'hFFFFFFFF);
    $display("DIVU 100/0 hi=%h lo=%h", hi, lo);

    // MTHI in idle, then a start/mtlo attempt while busy must be ignored.
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd40; b = 32'd7; mtlo = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("busy_ign_done", done, 1'b1);
    check("busy_ign_hi", hi, 32'h0);
    check("busy_ign_lo", lo, 32'd15);
    $display("MTHI+MULTU 3*5 hi=%h lo=%h", hi, lo);

    // Reset mid-operation discards the result; the next op runs normally.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    r = 1'b1;
    @(negedge clk);
    r = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_hi", hi, 32'h0);
    check("mid_rst_lo", lo, 32'h0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    do_op(2'b00, 32'd6, 32'd7, bc);
    check("after_rst_lo", lo, 32'd42);
    $display("reset mid-op then MULT 6*7 hi=%h lo=%h", hi, lo);

    // Randomized stream: every input toggles freely; the model tracks it.
    ndone = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        $display("rand result hi=%h lo=%h", hi, lo);
      end
      r     = ($urandom % 400) == 0;
      start = ($urandom % 6) == 0;
      op    = 2'($urandom);
      a     = pick();
      b     = pick();
      mthi  = ($urandom % 8) == 0;
      mtlo  = ($urandom % 8) == 0;
      wdata = $urandom;
    end
    @(negedge clk);
    r = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("rand_ops_completed", ndone > 20, 1'b1);
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
